// File: rtl/priority_irq_encoder_if.sv
`default_nettype none
// ============================================================================
// priority_irq_encoder_if : request/grant bundle for the priority IRQ encoder
// Revision: 1.0
// ============================================================================
interface priority_irq_encoder_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic [N-1:0] req;
    logic [N-1:0] mask;
    logic         ack;
    logic         valid;
    logic [W-1:0] id;
    logic [N-1:0] pending;

    modport master (
        output req,
        output mask,
        output ack,
        input  valid,
        input  id,
        input  pending
    );

    modport slave (
        input  req,
        input  mask,
        input  ack,
        output valid,
        output id,
        output pending
    );
endinterface
`default_nettype wire

// File: rtl/priority_irq_encoder.sv
`default_nettype none
// ============================================================================
// priority_irq_encoder : edge-captured, maskable, fixed/round-robin IRQ encoder
// Revision: 1.0
// ============================================================================
module priority_irq_encoder #(
    parameter int N  = 8,
    parameter int RR = 0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    priority_irq_encoder_if.slave  bus
);
    localparam int W = $clog2(N);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t       state_q;
    logic [N-1:0] req_q;
    logic [N-1:0] pending_q;
    logic [W-1:0] last_q;
    logic [W-1:0] id_q;
    logic         valid_q;

    logic [N-1:0] w_edge;
    logic [N-1:0] w_clear;
    logic [N-1:0] w_elig;
    logic [N-1:0] pending_d;
    logic [W-1:0] w_start;
    logic [W-1:0] w_sel;
    logic         w_any;

    assign w_edge    = bus.req & ~req_q;
    assign w_clear   = (state_q == GRANT && bus.ack) ? ({{(N-1){1'b0}}, 1'b1} << id_q) : '0;
    // OR-ing the edge after the clear lets a coincident new event survive the ack
    assign pending_d = (pending_q & ~w_clear) | w_edge;
    assign w_elig    = pending_q & ~bus.mask;
    assign w_any     = |w_elig;

    // Fixed priority is round-robin pinned at start 0: the scan begins at N-1
    assign w_start   = (RR != 0) ? last_q : '0;

    // Scan start-1, start-2, ... wrapping; iterate farthest first so the nearest hit wins
    always_comb begin : p_search
        int idx;
        idx   = 0;
        w_sel = '0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(w_start) >= k) ? int'(w_start) - k : int'(w_start) + N - k;
            if (w_elig[W'(idx)]) begin
                w_sel = W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= '0;
            pending_q <= '0;
            last_q    <= '0;
            id_q      <= '0;
            valid_q   <= 1'b0;
        end else begin
            req_q     <= bus.req;
            pending_q <= pending_d;
            case (state_q)
                IDLE: begin
                    if (w_any) begin
                        id_q    <= w_sel;
                        valid_q <= 1'b1;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (bus.ack) begin
                        valid_q <= 1'b0;
                        last_q  <= id_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.valid   = valid_q;
    assign bus.id      = id_q;
    assign bus.pending = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_priority_irq_encoder.sv
`default_nettype none
// ============================================================================
// tb_priority_irq_encoder : directed vector bench, fixed and round-robin modes
// Revision: 1.0
// ============================================================================
module tb_priority_irq_encoder;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    priority_irq_encoder_if #(.N(N)) bus_fx ();
    priority_irq_encoder_if #(.N(N)) bus_rr ();

    priority_irq_encoder #(.N(N), .RR(0)) dut_fx (
        .clk (clk),
        .rst (rst),
        .bus (bus_fx)
    );

    priority_irq_encoder #(.N(N), .RR(1)) dut_rr (
        .clk (clk),
        .rst (rst),
        .bus (bus_rr)
    );

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] mask;
        logic       ack;
        logic       valid;
        logic [2:0] id;
        logic [7:0] pend;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [7:0] rq, input logic [7:0] mk,
                       input logic a, input logic v, input logic [2:0] i,
                       input logic [7:0] p);
        vec_t t;
        t.rst = r; t.req = rq; t.mask = mk; t.ack = a;
        t.valid = v; t.id = i; t.pend = p;
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
    endtask

    // One cycle of the shared sequence: same req to both, per-instance ack
    task automatic dual(input int step, input logic [7:0] rq, input logic af, input logic ar,
                        input logic vf, input logic [2:0] idf, input logic [7:0] pf,
                        input logic vr, input logic [2:0] idr, input logic [7:0] pr);
        bus_fx.req = rq; bus_rr.req = rq;
        bus_fx.ack = af; bus_rr.ack = ar;
        @(posedge clk); #1;
        chk("fx.valid", step, 32'(bus_fx.valid), 32'(vf));
        chk("fx.id", step, 32'(bus_fx.id), 32'(idf));
        chk("fx.pending", step, 32'(bus_fx.pending), 32'(pf));
        chk("rr.valid", step, 32'(bus_rr.valid), 32'(vr));
        chk("rr.id", step, 32'(bus_rr.id), 32'(idr));
        chk("rr.pending", step, 32'(bus_rr.pending), 32'(pr));
    endtask

    initial begin
        //   rst  req    mask   ack  valid id  pending (after the edge)
        add(1, 8'hFF, 8'h00, 0, 0, 0, 8'h00);
        add(1, 8'hFF, 8'h00, 0, 0, 0, 8'h00);
        add(0, 8'hFF, 8'h00, 0, 0, 0, 8'hFF);
        add(0, 8'hFF, 8'h00, 0, 1, 7, 8'hFF);
        add(1, 8'h00, 8'h00, 0, 0, 0, 8'h00); // reset while granted
        add(0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
        add(0, 8'h24, 8'h00, 0, 0, 0, 8'h24);
        add(0, 8'h00, 8'h00, 0, 1, 5, 8'h24);
        add(0, 8'h00, 8'h00, 1, 0, 5, 8'h04);
        add(0, 8'h00, 8'h00, 0, 1, 2, 8'h04);
        add(0, 8'h00, 8'h00, 1, 0, 2, 8'h00);
        add(0, 8'h00, 8'h00, 0, 0, 2, 8'h00);
        add(0, 8'h01, 8'h00, 0, 0, 2, 8'h01); // held level, one event
        add(0, 8'h01, 8'h00, 0, 1, 0, 8'h01);
        add(0, 8'h01, 8'h00, 1, 0, 0, 8'h00);
        for (int i = 0; i < 7; i++) add(0, 8'h01, 8'h00, 0, 0, 0, 8'h00);
        add(0, 8'h00, 8'h00, 0, 0, 0, 8'h00);
        add(0, 8'h88, 8'h80, 0, 0, 0, 8'h88); // mask
        add(0, 8'h00, 8'h80, 0, 1, 3, 8'h88);
        add(0, 8'h00, 8'h80, 1, 0, 3, 8'h80);
        add(0, 8'h00, 8'h00, 0, 1, 7, 8'h80);
        add(0, 8'h00, 8'h80, 0, 1, 7, 8'h80);
        add(0, 8'h00, 8'h80, 1, 0, 7, 8'h00);
        add(0, 8'h00, 8'h00, 0, 0, 7, 8'h00);
        add(0, 8'h04, 8'h00, 0, 0, 7, 8'h04); // collision with ack
        add(0, 8'h00, 8'h00, 0, 1, 2, 8'h04);
        add(0, 8'h04, 8'h00, 1, 0, 2, 8'h04);
        add(0, 8'h00, 8'h00, 0, 1, 2, 8'h04);
        add(0, 8'h00, 8'h00, 1, 0, 2, 8'h00);
        add(0, 8'h00, 8'h00, 1, 0, 2, 8'h00); // ack in idle is ignored

        bus_rr.req = '0; bus_rr.mask = '0; bus_rr.ack = 1'b0;
        foreach (vecs[i]) begin
            rst         = vecs[i].rst;
            bus_fx.req  = vecs[i].req;
            bus_fx.mask = vecs[i].mask;
            bus_fx.ack  = vecs[i].ack;
            @(posedge clk); #1;
            chk("valid", i, 32'(bus_fx.valid), 32'(vecs[i].valid));
            chk("id", i, 32'(bus_fx.id), 32'(vecs[i].id));
            chk("pending", i, 32'(bus_fx.pending), 32'(vecs[i].pend));
        end

        // Fixed gives 7,4,7,0 while round-robin gives 7,4,0,7 for the same events
        rst = 1'b1; bus_fx.mask = '0;
        bus_fx.req = '0; bus_rr.req = '0; bus_fx.ack = 1'b0; bus_rr.ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        //    step req    afx arr  vf idf pf      vr idr pr
        dual(0, 8'h91, 0, 0,  0, 0, 8'h91,  0, 0, 8'h91);
        dual(1, 8'h00, 0, 0,  1, 7, 8'h91,  1, 7, 8'h91);
        dual(2, 8'h00, 1, 1,  0, 7, 8'h11,  0, 7, 8'h11);
        dual(3, 8'h00, 0, 0,  1, 4, 8'h11,  1, 4, 8'h11);
        dual(4, 8'h80, 0, 0,  1, 4, 8'h91,  1, 4, 8'h91);
        dual(5, 8'h00, 1, 1,  0, 4, 8'h81,  0, 4, 8'h81);
        dual(6, 8'h00, 0, 0,  1, 7, 8'h81,  1, 0, 8'h81);
        dual(7, 8'h00, 1, 1,  0, 7, 8'h01,  0, 0, 8'h80);
        dual(8, 8'h00, 0, 0,  1, 0, 8'h01,  1, 7, 8'h80);
        dual(9, 8'h00, 1, 1,  0, 0, 8'h00,  0, 7, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/priority_irq_encoder.md
# priority_irq_encoder

- Parametrised, clocked successor to the team's combinational 4-to-2 priority encoder.
- Captures rising edges on `N` request lines into sticky pending bits and applies a per-line mask.
- Selects one eligible line by fixed (highest index wins) or round-robin priority, then presents its index with a valid/ack handshake.
- Sits between raw event sources (buttons, peripheral flags) and a consumer FSM that services one event at a time.

## Interface
- `N`, 8: number of request lines; N ≥ 2, need not be a power of two.
- `RR`, 0: 0 = fixed priority, highest index wins; 1 = round-robin, rotating from the last acknowledged index.
- `W`, $clog2(N): index width; derived, never overridden.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input N: request lines, edge-sensitive (rising edge sets pending).
- `mask` input N: 1 = line ineligible for selection; its pending bit is kept.
- `ack` input 1: consumer accepts the presented index; sampled only while `valid`=1.
- `valid` output 1: registered; `id` holds a granted index.
- `id` output W: registered index of the granted line.
- `pending` output N: registered sticky pending vector, masked bits included.

## Operation
- Internal state: `req_q`[N], `pending`[N], `last`[W], and an FSM with states IDLE and GRANT.
- Edge capture, every cycle: `edge = req & ~req_q`; `req_q <= req`.
- Pending update: `pending <= (pending & ~clear) | edge`.
  - `clear` is one-hot at `id` only when state = GRANT and `ack` = 1; otherwise zero.
  - A new edge on the bit being cleared in the same cycle wins: the bit stays set.
- Eligible set: `elig = pending & ~mask`, computed from registered `pending`.
- Fixed mode (RR=0): select the highest set index of `elig`.
- Round-robin mode (RR=1): search downward starting at `last-1`, wrapping from 0 to N-1; `last` itself is checked last.
  - `last` resets to 0, so the first search starts at N-1 and matches fixed mode.
  - `last <= id` on each accepted `ack`.
- IDLE state:
  - If `elig` ≠ 0: register the selected index into `id`, set `valid`=1, go to GRANT.
  - Otherwise stay in IDLE; `valid`=0 and `id` holds its old value.
- GRANT state:
  - `valid` and `id` are frozen.
  - Mask changes and new edges do not revoke or change the grant.
  - On `ack`=1: clear the bit, set `valid`=0 next cycle, go to IDLE.
- `ack` in IDLE has no effect.
- Reset: `pending`=0, `req_q`=0, `valid`=0, `id`=0, `last`=0, state = IDLE.
  - Reset during GRANT drops the grant with no ack and discards all pending events.
  - A request held high through reset release registers one edge on the first post-reset cycle, because `req_q` is 0.

## Timing
- Latency: `req` rises before edge k → `pending` bit set after edge k → `valid`=1 and `id` valid after edge k+1. Two cycles from request to grant.
- A request that is already pending and unmasked: `valid` is asserted one cycle after entering IDLE.
- Ack → deassert: `ack` sampled at edge m → `valid`=0 after edge m.
- The earliest next grant is after edge m+1, so `valid` always drops for at least one cycle between grants. Peak throughput is one grant per two cycles.
- A level held high produces exactly one event; the line must return low for ≥1 cycle to produce another.
- A single-cycle `req` pulse is never lost if it is high at a rising edge.
- `pending` reflects captures and clears one cycle after the causing edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert `rst` 2 cycles with `req`=8'hFF → `valid`=0, `id`=0, `pending`=0. After release with `req` still high → `pending`=8'hFF one cycle later.
- Fixed order: pulse `req`=8'b0010_0100 for 1 cycle, ack each grant immediately → `id`=5 appears 2 cycles after the pulse. After ack, one idle cycle, then `id`=2; after its ack, `valid` stays 0 and `pending`=0.
- Edge-only: hold `req`=8'h01 for 10 cycles and ack the first grant → exactly one grant with `id`=0; no regrant while the line stays high.
- Mask: pending 8'h88 with `mask`=8'h80 → `id`=3. Ack it, then set `mask`=0 → `id`=7. While `id`=7 is granted, setting `mask`=8'h80 does not drop `valid`.
- Round-robin (RR=1): pending 8'h91 → `id`=7 then `id`=4. Pulse bit 7 again before acking 4 → next grants are `id`=0, then `id`=7. With RR=0 the same stimulus gives 7, 4, 7, 0.
- Collision and reset: an edge on bit 2 in the same cycle as the ack of `id`=2 → bit 2 remains pending and is regranted after one idle cycle. Asserting `rst` during GRANT → `valid`=0 and `pending`=0 on the next cycle.
